alu_share_arb: RTL and testbench

- Arbitrates a single shared ALU instance between two requesters: port 0 is the pipeline EX-stage helper and port 1 is the CSR/debug side path.
- Each requester presents operands plus a 3-bit ALUControl code (same encoding the ALU decoder produces) through a valid/ready handshake.
- The block registers the operands, drives the ALU and captures its result. It then returns the result to the winning requester through a valid/ready response channel.
- Sits beside the ALU in the execute stage. The ALU itself stays external and combinational.

---
 rtl/alu_share_arb_if.sv | 54 +++++
 rtl/alu_share_arb.sv | 109 ++++++++++
 tb/tb_alu_share_arb.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arb_if.sv
// Request/response and ALU-side signals of the shared-ALU arbiter.
// The arbiter connects through the slave modport. The requesters and the
// external combinational ALU connect through the master modport.
interface alu_share_arb_if #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
);
    // Requester 0
    logic              req0_valid_i;
    logic              req0_ready_o;
    logic [WIDTH-1:0]  req0_a_i;
    logic [WIDTH-1:0]  req0_b_i;
    logic [CTRL_W-1:0] req0_ctrl_i;
    logic              resp0_valid_o;
    logic              resp0_ready_i;
    logic [WIDTH-1:0]  resp0_result_o;
    logic              resp0_zero_o;

    // Requester 1
    logic              req1_valid_i;
    logic              req1_ready_o;
    logic [WIDTH-1:0]  req1_a_i;
    logic [WIDTH-1:0]  req1_b_i;
    logic [CTRL_W-1:0] req1_ctrl_i;
    logic              resp1_valid_o;
    logic              resp1_ready_i;
    logic [WIDTH-1:0]  resp1_result_o;
    logic              resp1_zero_o;

    // Shared ALU
    logic [WIDTH-1:0]  alu_a_o;
    logic [WIDTH-1:0]  alu_b_o;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic [WIDTH-1:0]  alu_result_i;
    logic              alu_zero_i;

    modport slave (
        input  req0_valid_i, req0_a_i, req0_b_i, req0_ctrl_i, resp0_ready_i,
        output req0_ready_o, resp0_valid_o, resp0_result_o, resp0_zero_o,
        input  req1_valid_i, req1_a_i, req1_b_i, req1_ctrl_i, resp1_ready_i,
        output req1_ready_o, resp1_valid_o, resp1_result_o, resp1_zero_o,
        output alu_a_o, alu_b_o, alu_ctrl_o,
        input  alu_result_i, alu_zero_i
    );

    modport master (
        output req0_valid_i, req0_a_i, req0_b_i, req0_ctrl_i, resp0_ready_i,
        input  req0_ready_o, resp0_valid_o, resp0_result_o, resp0_zero_o,
        output req1_valid_i, req1_a_i, req1_b_i, req1_ctrl_i, resp1_ready_i,
        input  req1_ready_o, resp1_valid_o, resp1_result_o, resp1_zero_o,
        input  alu_a_o, alu_b_o, alu_ctrl_o,
        output alu_result_i, alu_zero_i
    );
endinterface

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two requesters.
// Port 0 is the EX-stage helper and port 1 is the CSR/debug path.
// The arbiter grants round-robin on contention, registers the operands,
// captures the ALU result one cycle later, and holds it on the owner's
// response channel until that requester consumes it.
module alu_share_arb #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    alu_share_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner;
    logic              r_last_grant;
    logic [WIDTH-1:0]  r_alu_a;
    logic [WIDTH-1:0]  r_alu_b;
    logic [CTRL_W-1:0] r_alu_ctrl;
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic              r_resp0_valid;
    logic              r_resp1_valid;

    logic w_any_req;
    logic w_grant;
    logic w_idle;
    logic w_resp_ready;

    // The grant picks the lone requester. On contention it picks the port
    // that did not win last time. Ready is gated by rst_i so that it reads
    // 0 while reset is held, even with requests pending.
    assign w_any_req    = bus.req0_valid_i | bus.req1_valid_i;
    assign w_grant      = (bus.req0_valid_i & bus.req1_valid_i) ? ~r_last_grant
                                                                : bus.req1_valid_i;
    assign w_idle       = (r_state == IDLE) & ~rst_i;
    assign w_resp_ready = r_owner ? bus.resp1_ready_i : bus.resp0_ready_i;

    // The grant is combinational in IDLE, and only one port can be granted.
    assign bus.req0_ready_o = w_idle & w_any_req & ~w_grant;
    assign bus.req1_ready_o = w_idle & w_any_req &  w_grant;

    // The ALU sees only the registered operands.
    assign bus.alu_a_o    = r_alu_a;
    assign bus.alu_b_o    = r_alu_b;
    assign bus.alu_ctrl_o = r_alu_ctrl;

    // Both result buses show the same captured register; only valid qualifies them.
    assign bus.resp0_valid_o  = r_resp0_valid;
    assign bus.resp1_valid_o  = r_resp1_valid;
    assign bus.resp0_result_o = r_result;
    assign bus.resp1_result_o = r_result;
    assign bus.resp0_zero_o   = r_zero;
    assign bus.resp1_zero_o   = r_zero;

    // Arbitration FSM: accept in IDLE, capture in EXEC, hold the response in RESP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_ctrl    <= '0;
            r_result      <= '0;
            r_zero        <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_alu_a      <= w_grant ? bus.req1_a_i    : bus.req0_a_i;
                        r_alu_b      <= w_grant ? bus.req1_b_i    : bus.req0_b_i;
                        r_alu_ctrl   <= w_grant ? bus.req1_ctrl_i : bus.req0_ctrl_i;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_result      <= bus.alu_result_i;
                    r_zero        <= bus.alu_zero_i;
                    r_resp0_valid <= ~r_owner;
                    r_resp1_valid <=  r_owner;
                    r_state       <= RESP;
                end
                RESP: begin
                    if (w_resp_ready) begin
                        r_resp0_valid <= 1'b0;
                        r_resp1_valid <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with a small combinational ALU model.
module tb_alu_share_arb;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_share_arb_if #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) bus();

    alu_share_arb #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
    logic [WIDTH-1:0] alu_r;
    always_comb begin
        alu_r = '0;
        case (bus.alu_ctrl_o)
            3'b000: alu_r = bus.alu_a_o + bus.alu_b_o;
            3'b001: alu_r = bus.alu_a_o - bus.alu_b_o;
            3'b010: alu_r = bus.alu_a_o & bus.alu_b_o;
            3'b011: alu_r = bus.alu_a_o | bus.alu_b_o;
            3'b100: alu_r = bus.alu_a_o ^ bus.alu_b_o;
            3'b101: alu_r = ($signed(bus.alu_a_o) < $signed(bus.alu_b_o)) ? 32'd1 : 32'd0;
            3'b110: alu_r = bus.alu_a_o << bus.alu_b_o[4:0];
            default: alu_r = bus.alu_a_o >> bus.alu_b_o[4:0];
        endcase
    end
    assign bus.alu_result_i = alu_r;
    assign bus.alu_zero_i   = (alu_r == '0);

    typedef struct {
        logic        v0;
        logic [31:0] a0, b0;
        logic [2:0]  c0;
        logic        v1;
        logic [31:0] a1, b1;
        logic [2:0]  c1;
        logic        port;
        logic [31:0] res;
        logic        zero;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req0_valid_i  = 1'b0; bus.req0_a_i = '0; bus.req0_b_i = '0; bus.req0_ctrl_i = '0;
        bus.req1_valid_i  = 1'b0; bus.req1_a_i = '0; bus.req1_b_i = '0; bus.req1_ctrl_i = '0;
        bus.resp0_ready_i = 1'b0;
        bus.resp1_ready_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE; starts and ends 1 time unit after a rising edge.
    task automatic run_vec(input vec_t v, input int idx);
        bus.req0_valid_i = v.v0; bus.req0_a_i = v.a0; bus.req0_b_i = v.b0; bus.req0_ctrl_i = v.c0;
        bus.req1_valid_i = v.v1; bus.req1_a_i = v.a1; bus.req1_b_i = v.b1; bus.req1_ctrl_i = v.c1;
        bus.resp0_ready_i = 1'b0;
        bus.resp1_ready_i = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d idle ready0", idx), bus.req0_ready_o, !v.port);
        check($sformatf("v%0d idle ready1", idx), bus.req1_ready_o, v.port);
        check($sformatf("v%0d idle resp_valid", idx), {bus.resp0_valid_o, bus.resp1_valid_o}, 2'b00);
        step();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d exec readies", idx), {bus.req0_ready_o, bus.req1_ready_o}, 2'b00);
        check($sformatf("v%0d alu_a", idx), bus.alu_a_o, v.port ? v.a1 : v.a0);
        check($sformatf("v%0d alu_b", idx), bus.alu_b_o, v.port ? v.b1 : v.b0);
        check($sformatf("v%0d alu_ctrl", idx), bus.alu_ctrl_o, v.port ? v.c1 : v.c0);
        step();
        @(negedge clk);
        check($sformatf("v%0d resp0_valid", idx), bus.resp0_valid_o, !v.port);
        check($sformatf("v%0d resp1_valid", idx), bus.resp1_valid_o, v.port);
        check($sformatf("v%0d result", idx), v.port ? bus.resp1_result_o : bus.resp0_result_o, v.res);
        check($sformatf("v%0d zero", idx), v.port ? bus.resp1_zero_o : bus.resp0_zero_o, v.zero);
        bus.resp0_ready_i = !v.port;
        bus.resp1_ready_i = v.port;
        step();
        bus.resp0_ready_i = 1'b0;
        bus.resp1_ready_i = 1'b0;
    endtask

    initial begin
        logic [31:0] bb_a[4];
        logic [31:0] bb_b[4];
        logic [2:0]  bb_c[4];
        logic [31:0] bb_r[4];

        //          v0   a0             b0     c0      v1   a1     b1     c1      port  res     zero
        vecs[0] = '{1'b1, 32'd7,        32'd7, 3'b001, 1'b1, 32'd6,  32'd9, 3'b011, 1'b0, 32'd0,  1'b1};
        vecs[1] = '{1'b1, 32'd7,        32'd7, 3'b001, 1'b1, 32'd6,  32'd9, 3'b011, 1'b1, 32'd15, 1'b0};
        vecs[2] = '{1'b1, 32'd7,        32'd7, 3'b001, 1'b1, 32'd6,  32'd9, 3'b011, 1'b0, 32'd0,  1'b1};
        vecs[3] = '{1'b1, 32'd7,        32'd7, 3'b001, 1'b1, 32'd6,  32'd9, 3'b011, 1'b1, 32'd15, 1'b0};
        vecs[4] = '{1'b1, 32'd5,        32'd3, 3'b000, 1'b0, 32'd0,  32'd0, 3'b000, 1'b0, 32'd8,  1'b0};
        vecs[5] = '{1'b1, 32'd1,        32'd4, 3'b110, 1'b0, 32'd0,  32'd0, 3'b000, 1'b0, 32'd16, 1'b0};
        vecs[6] = '{1'b0, 32'd0,        32'd0, 3'b000, 1'b1, 32'd3,  32'd5, 3'b101, 1'b1, 32'd1,  1'b0};
        vecs[7] = '{1'b0, 32'd0,        32'd0, 3'b000, 1'b1, 32'hF,  32'h3, 3'b100, 1'b1, 32'd12, 1'b0};
        vecs[8] = '{1'b1, 32'hC,        32'hA, 3'b010, 1'b1, 32'd10, 32'd3, 3'b001, 1'b0, 32'd8,  1'b0};
        vecs[9] = '{1'b1, 32'hFFFFFFFF, 32'd1, 3'b000, 1'b1, 32'd10, 32'd3, 3'b001, 1'b1, 32'd7,  1'b0};

        bb_a = '{32'd1, 32'd3, 32'hF, 32'hC};
        bb_b = '{32'd4, 32'd5, 32'h3, 32'hA};
        bb_c = '{3'b110, 3'b101, 3'b100, 3'b010};
        bb_r = '{32'd16, 32'd1, 32'd12, 32'd8};

        // Reset state
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst readies", {bus.req0_ready_o, bus.req1_ready_o}, 2'b00);
        check("rst resp_valid", {bus.resp0_valid_o, bus.resp1_valid_o}, 2'b00);
        check("rst alu_a", bus.alu_a_o, 32'd0);
        check("rst alu_b", bus.alu_b_o, 32'd0);
        check("rst alu_ctrl", bus.alu_ctrl_o, 3'd0);
        check("rst result", bus.resp0_result_o, 32'd0);
        check("rst zero", {bus.resp0_zero_o, bus.resp1_zero_o}, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        // Idle: no requests for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("idle%0d hs", i),
                  {bus.req0_ready_o, bus.req1_ready_o, bus.resp0_valid_o, bus.resp1_valid_o}, 4'b0000);
            check($sformatf("idle%0d alu", i), {bus.alu_a_o, bus.alu_b_o}, 64'd0);
            check($sformatf("idle%0d result", i), bus.resp1_result_o, 32'd0);
        end
        step();

        // Table: contention alternation, single-port grants, mixed ops
        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Backpressure on port 1, with port 0 requesting while busy
        bus.req1_valid_i = 1'b1; bus.req1_a_i = 32'd6; bus.req1_b_i = 32'd9; bus.req1_ctrl_i = 3'b011;
        @(negedge clk);
        check("bp ready1", bus.req1_ready_o, 1'b1);
        step();
        bus.req1_valid_i = 1'b0;
        bus.req0_valid_i = 1'b1; bus.req0_a_i = 32'd5; bus.req0_b_i = 32'd3; bus.req0_ctrl_i = 3'b000;
        @(negedge clk);
        check("bp exec ready0", bus.req0_ready_o, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d resp1_valid", i), bus.resp1_valid_o, 1'b1);
            check($sformatf("bp%0d resp0_valid", i), bus.resp0_valid_o, 1'b0);
            check($sformatf("bp%0d result", i), bus.resp1_result_o, 32'd15);
            check($sformatf("bp%0d readies", i), {bus.req0_ready_o, bus.req1_ready_o}, 2'b00);
            step();
        end
        @(negedge clk);
        check("bp release valid", bus.resp1_valid_o, 1'b1);
        bus.resp1_ready_i = 1'b1;
        step();
        bus.resp1_ready_i = 1'b0;
        @(negedge clk);
        check("bp idle ready0", bus.req0_ready_o, 1'b1);
        check("bp idle resp1_valid", bus.resp1_valid_o, 1'b0);
        step();
        bus.req0_valid_i = 1'b0;
        @(negedge clk);
        check("bp next alu_a", bus.alu_a_o, 32'd5);
        step();
        @(negedge clk);
        check("bp next resp0_valid", bus.resp0_valid_o, 1'b1);
        check("bp next result", bus.resp0_result_o, 32'd8);
        bus.resp0_ready_i = 1'b1;
        step();
        bus.resp0_ready_i = 1'b0;

        // Back-to-back on port 0 with valid held high
        bus.req0_valid_i  = 1'b1;
        bus.resp0_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.req0_a_i = bb_a[k]; bus.req0_b_i = bb_b[k]; bus.req0_ctrl_i = bb_c[k];
            @(negedge clk);
            check($sformatf("b2b%0d accept", k), bus.req0_ready_o, 1'b1);
            step();
            @(negedge clk);
            check($sformatf("b2b%0d busy", k), bus.req0_ready_o, 1'b0);
            step();
            @(negedge clk);
            check($sformatf("b2b%0d resp0_valid", k), bus.resp0_valid_o, 1'b1);
            check($sformatf("b2b%0d result", k), bus.resp0_result_o, bb_r[k]);
            check($sformatf("b2b%0d ready0", k), bus.req0_ready_o, 1'b0);
            step();
        end
        bus.req0_valid_i  = 1'b0;
        bus.resp0_ready_i = 1'b0;

        // Async reset in EXEC after a port-0 grant
        bus.req0_valid_i = 1'b1; bus.req0_a_i = 32'd9; bus.req0_b_i = 32'd4; bus.req0_ctrl_i = 3'b000;
        @(negedge clk);
        check("ar accept0", bus.req0_ready_o, 1'b1);
        step();
        bus.req1_valid_i = 1'b1; bus.req1_a_i = 32'd2; bus.req1_b_i = 32'd2; bus.req1_ctrl_i = 3'b000;
        check("ar exec alu_a", bus.alu_a_o, 32'd9);
        #2;
        rst = 1'b1;
        #1;
        check("ar alu_a", bus.alu_a_o, 32'd0);
        check("ar alu_ctrl", bus.alu_ctrl_o, 3'd0);
        check("ar readies", {bus.req0_ready_o, bus.req1_ready_o}, 2'b00);
        check("ar resp_valid", {bus.resp0_valid_o, bus.resp1_valid_o}, 2'b00);
        check("ar result", bus.resp0_result_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ar post ready0", bus.req0_ready_o, 1'b1);
        check("ar post ready1", bus.req1_ready_o, 1'b0);
        check("ar post resp_valid", {bus.resp0_valid_o, bus.resp1_valid_o}, 2'b00);
        step();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        @(negedge clk);
        check("ar post exec resp_valid", {bus.resp0_valid_o, bus.resp1_valid_o}, 2'b00);
        step();
        @(negedge clk);
        check("ar post resp0_valid", bus.resp0_valid_o, 1'b1);
        check("ar post result", bus.resp0_result_o, 32'd13);
        bus.resp0_ready_i = 1'b1;
        step();
        bus.resp0_ready_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
